// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared types and default constants for the data-memory arbiter.
//   owner_e    : which port currently holds a locked grant (none / A / B)
//   port_sel_e : port selector, used for the last-served port
//   *_DEF      : default values for the dataWidth, N and MAX_BURST parameters
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int N_DEF          = 55;
    localparam int MAX_BURST_DEF  = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } port_sel_e;

endpackage

// File: rtl/dmem_arbiter_rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Grant logic for the two-port data-memory arbiter.
// Holds the lock owner, the last-served port and the burst counter.
// A locked owner keeps the grant until it has been granted MAX_BURST times in
// a row while the other port waits. After that, ties go to the port that was
// not served last.
//   clk, rst_n     : clock, asynchronous active-low reset
//   a_req, a_lock  : port A request / hold-grant
//   b_req, b_lock  : port B request / hold-grant
//   a_gnt, b_gnt   : combinational one-hot (or zero) grants
// -----------------------------------------------------------------------------
module rr_grant
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_req,
    input  logic a_lock,
    input  logic b_req,
    input  logic b_lock,
    output logic a_gnt,
    output logic b_gnt
);

    localparam int              CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    owner_e           owner_q, owner_d;
    port_sel_e        last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_a;
    logic             hold_b;

    // Grant selection and next-state computation
    always_comb begin
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        owner_d = OWN_NONE;
        last_d  = last_q;
        cnt_d   = {CNT_W{1'b0}};
        // The owner keeps the grant while its burst budget lasts, or for as long
        // as nobody else is waiting.
        hold_a  = (owner_q == OWN_A) && a_req && a_lock && ((cnt_q < CNT_MAX) || !b_req);
        hold_b  = (owner_q == OWN_B) && b_req && b_lock && ((cnt_q < CNT_MAX) || !a_req);

        // Grants are forced low during reset so that the memory sees no access.
        if (!rst_n) begin
            a_gnt = 1'b0;
        end else if (hold_a) begin
            a_gnt = 1'b1;
        end else if (hold_b) begin
            b_gnt = 1'b1;
        end else if (a_req && b_req) begin
            if (last_q == SEL_A) begin
                b_gnt = 1'b1;
            end else begin
                a_gnt = 1'b1;
            end
        end else if (a_req) begin
            a_gnt = 1'b1;
        end else if (b_req) begin
            b_gnt = 1'b1;
        end else begin
            a_gnt = 1'b0;
        end

        if (a_gnt) begin
            last_d  = SEL_A;
            owner_d = a_lock ? OWN_A : OWN_NONE;
            if (owner_q == OWN_A) begin
                cnt_d = (cnt_q < CNT_MAX) ? (cnt_q + CNT_W'(1)) : CNT_MAX;
            end else begin
                cnt_d = {CNT_W{1'b0}};
            end
        end else if (b_gnt) begin
            last_d  = SEL_B;
            owner_d = b_lock ? OWN_B : OWN_NONE;
            if (owner_q == OWN_B) begin
                cnt_d = (cnt_q < CNT_MAX) ? (cnt_q + CNT_W'(1)) : CNT_MAX;
            end else begin
                cnt_d = {CNT_W{1'b0}};
            end
        end else begin
            owner_d = OWN_NONE;
            cnt_d   = {CNT_W{1'b0}};
        end
    end

    // Arbitration state registers. After reset, last-served is B so that A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
            last_q  <= SEL_B;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-port arbiter in front of a single-port, asynchronous-read data memory.
// Port A is the pipeline MEM stage and port B is the loader/debug port.
//   CLK, RST_N                        : clock, asynchronous active-low reset
//   x_req/x_we/x_lock/x_adrs/x_wd     : port request, write, hold-grant, address, data
//   x_gnt                             : combinational grant
//   x_rdata/x_rvalid/x_err            : registered read data, read-valid and range-error
//   mem_we/mem_adrs/mem_wd            : memory drive (zero when idle)
//   mem_rdata                         : asynchronous memory read data
// Accesses at addresses >= N are turned into an error response. Writes to
// such addresses are suppressed, and reads to them return zero.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int dataWidth = DATA_WIDTH_DEF,
    parameter int N         = N_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic                 a_lock,
    input  logic [dataWidth-1:0] a_adrs,
    input  logic [dataWidth-1:0] a_wd,
    output logic                 a_gnt,
    output logic [dataWidth-1:0] a_rdata,
    output logic                 a_rvalid,
    output logic                 a_err,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic                 b_lock,
    input  logic [dataWidth-1:0] b_adrs,
    input  logic [dataWidth-1:0] b_wd,
    output logic                 b_gnt,
    output logic [dataWidth-1:0] b_rdata,
    output logic                 b_rvalid,
    output logic                 b_err,
    output logic                 mem_we,
    output logic [dataWidth-1:0] mem_adrs,
    output logic [dataWidth-1:0] mem_wd,
    input  logic [dataWidth-1:0] mem_rdata
);

    localparam logic [dataWidth-1:0] N_ADRS = dataWidth'(N);

    logic                 a_in_range;
    logic                 b_in_range;
    logic [dataWidth-1:0] a_rdata_q, a_rdata_d;
    logic                 a_rvalid_q, a_rvalid_d;
    logic                 a_err_q, a_err_d;
    logic [dataWidth-1:0] b_rdata_q, b_rdata_d;
    logic                 b_rvalid_q, b_rvalid_d;
    logic                 b_err_q, b_err_d;

    rr_grant #(
        .MAX_BURST (MAX_BURST)
    ) u_rr_grant (
        .clk    (CLK),
        .rst_n  (RST_N),
        .a_req  (a_req),
        .a_lock (a_lock),
        .b_req  (b_req),
        .b_lock (b_lock),
        .a_gnt  (a_gnt),
        .b_gnt  (b_gnt)
    );

    assign a_in_range = (a_adrs < N_ADRS);
    assign b_in_range = (b_adrs < N_ADRS);

    // Memory bus mux: the granted port drives the memory, and an idle bus is all-zero.
    always_comb begin
        mem_we   = 1'b0;
        mem_adrs = {dataWidth{1'b0}};
        mem_wd   = {dataWidth{1'b0}};
        if (a_gnt) begin
            mem_we   = a_we & a_in_range;
            mem_adrs = a_adrs;
            mem_wd   = a_wd;
        end else if (b_gnt) begin
            mem_we   = b_we & b_in_range;
            mem_adrs = b_adrs;
            mem_wd   = b_wd;
        end else begin
            mem_we   = 1'b0;
        end
    end

    // Read-return next state. Read data is held through writes and idle cycles.
    always_comb begin
        a_rdata_d  = a_rdata_q;
        a_rvalid_d = 1'b0;
        a_err_d    = 1'b0;
        b_rdata_d  = b_rdata_q;
        b_rvalid_d = 1'b0;
        b_err_d    = 1'b0;
        if (a_gnt) begin
            a_rvalid_d = ~a_we;
            a_err_d    = ~a_in_range;
            if (!a_we) begin
                a_rdata_d = a_in_range ? mem_rdata : {dataWidth{1'b0}};
            end else begin
                a_rdata_d = a_rdata_q;
            end
        end else begin
            a_rvalid_d = 1'b0;
        end
        if (b_gnt) begin
            b_rvalid_d = ~b_we;
            b_err_d    = ~b_in_range;
            if (!b_we) begin
                b_rdata_d = b_in_range ? mem_rdata : {dataWidth{1'b0}};
            end else begin
                b_rdata_d = b_rdata_q;
            end
        end else begin
            b_rvalid_d = 1'b0;
        end
    end

    // Read-return registers. Reset discards any read that is still in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_rdata_q  <= {dataWidth{1'b0}};
            a_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            b_rdata_q  <= {dataWidth{1'b0}};
            b_rvalid_q <= 1'b0;
            b_err_q    <= 1'b0;
        end else begin
            a_rdata_q  <= a_rdata_d;
            a_rvalid_q <= a_rvalid_d;
            a_err_q    <= a_err_d;
            b_rdata_q  <= b_rdata_d;
            b_rvalid_q <= b_rvalid_d;
            b_err_q    <= b_err_d;
        end
    end

    assign a_rdata  = a_rdata_q;
    assign a_rvalid = a_rvalid_q;
    assign a_err    = a_err_q;
    assign b_rdata  = b_rdata_q;
    assign b_rvalid = b_rvalid_q;
    assign b_err    = b_err_q;

endmodule
